// File: rtl/up_counter_if.sv
// Control and status bundle for up_counter_mod. The master drives the controls
// and the slave (the counter) drives the status outputs.
interface up_counter_if #(parameter int N = 5);
  logic         clr;
  logic         load;
  logic [N-1:0] load_val;
  logic         en;
  logic         one_shot;
  logic [N-1:0] counter;
  logic         tc;
  logic         carry;
  logic         done;
  logic         ld_err;

  modport master (output clr, load, load_val, en, one_shot,
                  input  counter, tc, carry, done, ld_err);
  modport slave  (input  clr, load, load_val, en, one_shot,
                  output counter, tc, carry, done, ld_err);
endinterface

// File: rtl/up_counter_mod.sv
// N-bit modulo-MOD up counter with clear, saturating load, one-shot halt and a
// registered carry pulse that can drive the next stage's en when cascading.
module up_counter_mod #(
  parameter int N   = 5,
  parameter int MOD = 32
) (
  input  logic        clk,
  input  logic        reset,
  up_counter_if.slave bus
);

  if (MOD < 2 || longint'(MOD) > (longint'(1) << N)) begin : g_bad_mod
    $error("up_counter_mod: MOD=%0d is outside 2..2**%0d", MOD, N);
  end

  localparam logic [N-1:0] TC_VAL = N'(MOD - 1);
  localparam logic [0:0]   RUN    = 1'b0;
  localparam logic [0:0]   HALT   = 1'b1;

  logic [N-1:0] cnt_q;
  logic [0:0]   state_q;
  logic         carry_q;
  logic         err_q;
  logic         at_tc;

  assign at_tc = (cnt_q == TC_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= RUN;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.clr) begin
      cnt_q   <= '0;
      state_q <= RUN;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.load) begin
      // Out-of-range loads saturate to the terminal value and latch the error.
      if (bus.load_val > TC_VAL) begin
        cnt_q <= TC_VAL;
        err_q <= 1'b1;
      end else begin
        cnt_q <= bus.load_val;
      end
      state_q <= RUN;
      carry_q <= 1'b0;
    end else if (state_q == RUN && bus.en) begin
      if (at_tc) begin
        carry_q <= 1'b1;
        // one_shot only matters here, on the terminal edge.
        if (bus.one_shot) state_q <= HALT;
        else              cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
        carry_q <= 1'b0;
      end
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.counter = cnt_q;
  assign bus.tc      = at_tc;
  assign bus.carry   = carry_q;
  assign bus.done    = (state_q == HALT);
  assign bus.ld_err  = err_q;

endmodule

// File: tb/tb_up_counter_mod.sv
// Bench for up_counter_mod: three instances (MOD=32, MOD=10, MOD=2) covering
// wrap, one-shot halt, load saturation, priority, async reset and random traffic.
module tb_up_counter_mod;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  up_counter_if #(.N(5)) b32 ();
  up_counter_if #(.N(4)) b10 ();
  up_counter_if #(.N(1)) b2  ();

  up_counter_mod #(.N(5), .MOD(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  up_counter_mod #(.N(4), .MOD(10)) u10 (.clk(clk), .reset(reset), .bus(b10));
  up_counter_mod #(.N(1), .MOD(2))  u2  (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic clr, load; int lv; logic en, os;
    int   cnt; logic tc, cy, dn, er;
  } vec_t;

  typedef struct { int cnt; bit halt; bit carry; bit err; } mdl_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counting seen as arithmetic mod `mod`; a step that lands on 0 is a terminal event.
  function automatic mdl_t mstep(mdl_t s, int mod, bit clr, bit load, int lv, bit en, bit os);
    mdl_t n = s;
    int nxt;
    n.carry = 0;
    if (clr) begin
      n = '{0, 0, 0, 0};
    end else if (load) begin
      n.cnt  = (lv < mod) ? lv : mod - 1;
      n.err  = s.err | (lv >= mod);
      n.halt = 0;
    end else if (en && !s.halt) begin
      nxt = (s.cnt + 1) % mod;
      if (nxt == 0) begin
        n.carry = 1;
        if (os) n.halt = 1;
        else    n.cnt  = 0;
      end else begin
        n.cnt = nxt;
      end
    end
    return n;
  endfunction

  task automatic apply10(input vec_t v, input int idx);
    string tag;
    b10.clr = v.clr; b10.load = v.load; b10.load_val = 4'(v.lv);
    b10.en = v.en; b10.one_shot = v.os;
    tick();
    tag = $sformatf("tbl%0d", idx);
    chk({tag, ".counter"}, b10.counter, v.cnt);
    chk({tag, ".tc"},      b10.tc,      v.tc);
    chk({tag, ".carry"},   b10.carry,   v.cy);
    chk({tag, ".done"},    b10.done,    v.dn);
    chk({tag, ".ld_err"},  b10.ld_err,  v.er);
  endtask

  initial begin
    mdl_t m;
    int   exp_c;

    {b32.clr, b32.load, b32.load_val, b32.en, b32.one_shot} = '0;
    {b10.clr, b10.load, b10.load_val, b10.en, b10.one_shot} = '0;
    {b2.clr,  b2.load,  b2.load_val,  b2.en,  b2.one_shot}  = '0;
    reset = 1'b0;
    #3;
    b32.en = 1'b1;
    b2.en  = 1'b1;
    #10;
    chk("rst.c32",   b32.counter, 0);
    chk("rst.carry", b32.carry,   0);
    chk("rst.done",  b10.done,    0);
    chk("rst.err",   b10.ld_err,  0);
    chk("rst.c2",    b2.counter,  0);
    tick();
    chk("rst.hold", b32.counter, 0);

    // Free-run 0..31 then wrap; u10 is parked in HALT alongside.
    b2.en = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 49; i++) begin
      b10.load = (i == 0); b10.load_val = 4'd8;
      b10.en = (i != 0);   b10.one_shot = 1'b1;
      tick();
      exp_c = (i + 1) % 32;
      if (i < 40) begin
        chk($sformatf("run%0d.cnt", i),   b32.counter, exp_c);
        chk($sformatf("run%0d.tc", i),    b32.tc,      exp_c == 31);
        chk($sformatf("run%0d.carry", i), b32.carry,   i == 31);
      end
    end
    chk("mid.cnt17",  b32.counter, 17);
    chk("halt.done",  b10.done,    1);
    chk("halt.cnt",   b10.counter, 9);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    {b10.clr, b10.load, b10.load_val, b10.en, b10.one_shot} = '0;
    #1;
    chk("arst.c32",   b32.counter, 0);
    chk("arst.cy32",  b32.carry,   0);
    chk("arst.done",  b10.done,    0);
    chk("arst.c10",   b10.counter, 0);
    tick();
    tick();
    @(negedge clk) reset = 1'b1;
    tick();
    chk("resume.c32", b32.counter, 1);
    b32.en = 1'b0;

    tbl.push_back('{1,1,5,1,0,  0,0,0,0,0});
    tbl.push_back('{0,1,5,1,0,  5,0,0,0,0});
    tbl.push_back('{0,0,0,1,0,  6,0,0,0,0});
    tbl.push_back('{0,1,7,0,0,  7,0,0,0,0});
    tbl.push_back('{0,0,0,1,1,  8,0,0,0,0});
    tbl.push_back('{0,0,0,1,1,  9,1,0,0,0});
    tbl.push_back('{0,0,0,1,1,  9,1,1,1,0});
    tbl.push_back('{0,0,0,1,0,  9,1,0,1,0});
    tbl.push_back('{0,0,0,1,0,  9,1,0,1,0});
    tbl.push_back('{1,0,0,1,0,  0,0,0,0,0});
    tbl.push_back('{0,1,12,0,0, 9,1,0,0,1});
    tbl.push_back('{0,1,3,0,0,  3,0,0,0,1});
    tbl.push_back('{0,0,0,0,0,  3,0,0,0,1});
    tbl.push_back('{0,0,0,1,0,  4,0,0,0,1});
    tbl.push_back('{1,0,0,0,0,  0,0,0,0,0});
    tbl.push_back('{0,1,9,0,0,  9,1,0,0,0});
    tbl.push_back('{0,0,0,1,0,  0,0,1,0,0});
    tbl.push_back('{0,0,0,1,0,  1,0,0,0,0});
    tbl.push_back('{0,1,15,1,0, 9,1,0,0,1});
    tbl.push_back('{0,1,0,0,0,  0,0,0,0,1});
    tbl.push_back('{0,1,8,0,0,  8,0,0,0,1});
    tbl.push_back('{0,0,0,1,1,  9,1,0,0,1});
    tbl.push_back('{0,0,0,1,1,  9,1,1,1,1});
    tbl.push_back('{0,1,2,1,1,  2,0,0,0,1});
    tbl.push_back('{0,0,0,1,1,  3,0,0,0,1});
    foreach (tbl[k]) apply10(tbl[k], k);

    // Two-state instance: back-to-back wraps, then en dropped.
    b2.clr = 1'b1; tick(); b2.clr = 1'b0;
    b2.en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("m2.%0d.cnt", i),   b2.counter, i % 2);
      chk($sformatf("m2.%0d.carry", i), b2.carry,   (i % 2) == 0);
    end
    b2.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("m2.hold%0d.cnt", i),   b2.counter, 0);
      chk($sformatf("m2.hold%0d.carry", i), b2.carry,   0);
    end

    // Random traffic on the MOD=10 instance against the model.
    b10.clr = 1'b1; b10.load = 1'b0; b10.en = 1'b0;
    tick();
    m = '{0, 0, 0, 0};
    for (int i = 0; i < 400; i++) begin
      logic c, l, e, o;
      int   lv;
      c  = ($urandom_range(31) == 0);
      l  = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      o  = $urandom_range(1);
      lv = $urandom_range(15);
      b10.clr = c; b10.load = l; b10.load_val = 4'(lv); b10.en = e; b10.one_shot = o;
      m = mstep(m, 10, c, l, lv, e, o);
      tick();
      chk($sformatf("rnd%0d.cnt", i),   b10.counter, m.cnt);
      chk($sformatf("rnd%0d.tc", i),    b10.tc,      m.cnt == 9);
      chk($sformatf("rnd%0d.carry", i), b10.carry,   m.carry);
      chk($sformatf("rnd%0d.done", i),  b10.done,    m.halt);
      chk($sformatf("rnd%0d.err", i),   b10.ld_err,  m.err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
